mouse_cursor_overlay: RTL and testbench
=======================================

MOUSE_CURSOR_OVERLAY -- requirements
Module: mouse_cursor_overlay

Interface
REQ-001 clock  input  1  system clock, 100 MHz; all logic on its rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 mouse_x  input  10  cursor column, from the PS/2 mouse decoder; range 0..639.
REQ-004 mouse_y  input  10  cursor row, from the PS/2 mouse decoder; range 0..495.
REQ-005 mouse_buttons  input  3  [0]=left, [1]=right, [2]=middle; 1=pressed.
REQ-006 cursor_enable  input  1  1=draw cursor; sampled at frame_start only.
REQ-007 in_valid, in_hsync, in_vsync  input  1 each  video timing from the pixel generator.
REQ-008 in_x, in_y  input  10 each  coordinates of the current pixel.
REQ-009 in_color  input  8  background pixel, RGB332.
REQ-010 frame_start  input  1  one-cycle pulse before the first pixel of each frame.
REQ-011 bm_we  input  1  bitmap write strobe.
REQ-012 bm_addr  input  8  bitmap write address, {row[3:0],col[3:0]}.
REQ-013 bm_data  input  2  bitmap write data.
REQ-014 out_valid, out_hsync, out_vsync  output  1 each  input timing delayed by 2 cycles.
REQ-015 out_color  output  8  composited pixel, RGB332.

Function
REQ-016 Latency from in_* to out_* SHALL be exactly 2 cycles; all sideband signals SHALL be delayed identically. No stalls.
REQ-017 On frame_start=1 the block SHALL latch mouse_x, mouse_y, mouse_buttons and cursor_enable into cur_x, cur_y, cur_btn and cur_en; the latched values SHALL NOT change mid-frame.
REQ-018 If frame_start and a mouse input change occur in the same cycle, the input value present in that cycle SHALL be latched.
REQ-019 Stage 1 SHALL compute dx=in_x-cur_x and dy=in_y-cur_y in 11-bit two's complement. hit=cur_en & in_valid & 0<=dx<16 & 0<=dy<16. No wrap-around: a cursor at x=630 SHALL draw columns 630..639 only.
REQ-020 Stage 1 SHALL read the bitmap at {dy[3:0],dx[3:0]}; the code SHALL be registered with hit and in_color.
REQ-021 Stage 2 colour code mapping, with hit=0 treated as code 0:
  - 0: transparent; output in_color.
  - 1: outline; output 8'h00.
  - 2: fill; output 8'hFF, or 8'hFC if cur_btn[0]=1, or 8'hE0 if cur_btn[1]=1 (left takes priority over right).
  - 3: invert; output ~in_color.
REQ-022 When out_valid=0, out_color SHALL be 8'h00.
REQ-023 The bitmap SHALL be 256x2. A write takes effect on the next clock edge. A read and a write to the same address in the same cycle SHALL return the old data.
REQ-024 Bitmap writes SHALL be accepted in any cycle, including mid-frame; they have no handshake.

Reset
REQ-025 On reset, all pipeline registers and outputs SHALL be 0, so out_color=8'h00 and out_valid/out_hsync/out_vsync=0 from the next cycle.
REQ-026 On reset, cur_x, cur_y, cur_btn and cur_en SHALL be 0; the cursor stays hidden until the next frame_start with cursor_enable=1.
REQ-027 Bitmap contents SHALL NOT be reset.
REQ-028 Reset asserted mid-frame SHALL flush both pipeline stages. Output SHALL resume 2 cycles after the first valid input following reset release.

Structure
REQ-029 Package mouse_pkg SHALL hold:
  - CURSOR_SIZE=16;
  - RGB332 colour constants (COL_BLACK, COL_WHITE, COL_LEFT, COL_RIGHT);
  - the 2-bit cursor code enum (TRANSPARENT, OUTLINE, FILL, INVERT);
  - SCREEN_W=640, SCREEN_H=496.
REQ-030 The bitmap SHALL be the sub-module cursor_bitmap_ram: 256x2, one synchronous write port and one synchronous read port, inferable as distributed RAM.

Verification
REQ-031 Write rows 0..15 with code 2; frame_start with mouse=(100,50), enable=1 -> pixels (100..115, 50..65) are 8'hFF 2 cycles after input; pixel (116,50) passes in_color through.
REQ-032 mouse_x changes 100->200 mid-frame -> cursor remains at x=100 until the next frame_start, then draws at x=200.
REQ-033 Cursor at (630,490) -> only columns 630..639 and rows 490..495 are altered; pixel (0,0) and row 0 are unaffected (no wrap).
REQ-034 Code 3 at bitmap offset (0,0), in_color=8'h5A -> out_color=8'hA5. Code 2 with mouse_buttons=3'b011 -> out_color=8'hFC.
REQ-035 Assert reset for 1 cycle mid-line -> out_valid=0 and out_color=0 the next cycle; cursor hidden until frame_start with enable=1.
REQ-036 bm_we to address 0x00 in the same cycle as a read of 0x00 -> old code is displayed; the new code appears on the next access.

Source files
------------

// File: rtl/mouse_pkg.sv
// Shared constants and types for the mouse cursor overlay.
// Colours are RGB332. Screen size is in pixels.
package mouse_pkg;

   localparam int CURSOR_SIZE = 16;
   localparam int SCREEN_W    = 640;
   localparam int SCREEN_H    = 496;

   localparam logic [7:0] COL_BLACK = 8'h00;
   localparam logic [7:0] COL_WHITE = 8'hFF;
   localparam logic [7:0] COL_LEFT  = 8'hFC;
   localparam logic [7:0] COL_RIGHT = 8'hE0;

   typedef enum logic [1:0] {
      TRANSPARENT = 2'd0,
      OUTLINE     = 2'd1,
      FILL        = 2'd2,
      INVERT      = 2'd3
   } cursor_code_e;

   // Fill colour tracks the latched buttons; left wins over right.
   function automatic logic [7:0] fill_color(input logic left, input logic right);
      if (left)       return COL_LEFT;
      else if (right) return COL_RIGHT;
      else            return COL_WHITE;
   endfunction

endpackage

// File: rtl/cursor_bitmap_ram.sv
// 256x2 cursor bitmap: one synchronous write port and one registered read port.
// A read and a write to the same address in one cycle return the old data.
module cursor_bitmap_ram
   import mouse_pkg::*;
(
   input  logic       clock,
   input  logic       we,
   input  logic [7:0] wr_addr,
   input  logic [1:0] wr_data,
   input  logic [7:0] rd_addr,
   output logic [1:0] rd_data
);

   localparam int DEPTH = CURSOR_SIZE * CURSOR_SIZE;

   logic [1:0] mem [DEPTH];

   // Contents are deliberately not reset.
   always_ff @(posedge clock) begin
      if (we) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/mouse_cursor_overlay.sv
// Two-stage pipeline that composites a 16x16 cursor bitmap over the video stream.
// Stage 1 does the hit test and bitmap read; stage 2 applies the colour code.
module mouse_cursor_overlay
   import mouse_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [9:0] mouse_x,
   input  logic [9:0] mouse_y,
   input  logic [2:0] mouse_buttons,
   input  logic       cursor_enable,
   input  logic       in_valid,
   input  logic       in_hsync,
   input  logic       in_vsync,
   input  logic [9:0] in_x,
   input  logic [9:0] in_y,
   input  logic [7:0] in_color,
   input  logic       frame_start,
   input  logic       bm_we,
   input  logic [7:0] bm_addr,
   input  logic [1:0] bm_data,
   output logic       out_valid,
   output logic       out_hsync,
   output logic       out_vsync,
   output logic [7:0] out_color
);

   logic [9:0]  cur_x, cur_y;
   logic [2:0]  cur_btn;
   logic        cur_en;

   logic [10:0] dx, dy;
   logic        hit;

   logic        s1_valid, s1_hsync, s1_vsync, s1_hit;
   logic [7:0]  s1_color;
   logic [1:0]  s1_code_raw;

   cursor_code_e code;
   logic [7:0]   mix_color;
   logic         btn_middle_unused;

   always_ff @(posedge clock) begin
      if (reset) begin
         cur_x   <= '0;
         cur_y   <= '0;
         cur_btn <= '0;
         cur_en  <= 1'b0;
      end else if (frame_start) begin
         cur_x   <= mouse_x;
         cur_y   <= mouse_y;
         cur_btn <= mouse_buttons;
         cur_en  <= cursor_enable;
      end
   end

   assign btn_middle_unused = cur_btn[2];

   // Unsigned compare against 16 also rejects negative offsets, so no wrap-around.
   assign dx  = {1'b0, in_x} - {1'b0, cur_x};
   assign dy  = {1'b0, in_y} - {1'b0, cur_y};
   assign hit = cur_en && in_valid &&
                (dx < 11'(CURSOR_SIZE)) && (dy < 11'(CURSOR_SIZE));

   cursor_bitmap_ram u_bitmap (
      .clock   (clock),
      .we      (bm_we),
      .wr_addr (bm_addr),
      .wr_data (bm_data),
      .rd_addr ({dy[3:0], dx[3:0]}),
      .rd_data (s1_code_raw)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_hsync <= 1'b0;
         s1_vsync <= 1'b0;
         s1_hit   <= 1'b0;
         s1_color <= '0;
      end else begin
         s1_valid <= in_valid;
         s1_hsync <= in_hsync;
         s1_vsync <= in_vsync;
         s1_hit   <= hit;
         s1_color <= in_color;
      end
   end

   always_comb begin
      code      = s1_hit ? cursor_code_e'(s1_code_raw) : TRANSPARENT;
      mix_color = s1_color;
      case (code)
         TRANSPARENT: mix_color = s1_color;
         OUTLINE:     mix_color = COL_BLACK;
         FILL:        mix_color = fill_color(cur_btn[0], cur_btn[1]);
         INVERT:      mix_color = ~s1_color;
         default:     mix_color = s1_color;
      endcase
      if (!s1_valid) mix_color = COL_BLACK;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_hsync <= 1'b0;
         out_vsync <= 1'b0;
         out_color <= '0;
      end else begin
         out_valid <= s1_valid;
         out_hsync <= s1_hsync;
         out_vsync <= s1_vsync;
         out_color <= mix_color;
      end
   end

endmodule

// File: tb/tb_mouse_cursor_overlay.sv
// Scoreboard bench for mouse_cursor_overlay: each driven cycle pushes its
// expected output, which is popped and compared two cycles later.
module tb_mouse_cursor_overlay;
   import mouse_pkg::*;

   logic       clock = 1'b0;
   logic       reset;
   logic [9:0] mouse_x, mouse_y;
   logic [2:0] mouse_buttons;
   logic       cursor_enable;
   logic       in_valid, in_hsync, in_vsync;
   logic [9:0] in_x, in_y;
   logic [7:0] in_color;
   logic       frame_start;
   logic       bm_we;
   logic [7:0] bm_addr;
   logic [1:0] bm_data;
   logic       out_valid, out_hsync, out_vsync;
   logic [7:0] out_color;

   mouse_cursor_overlay dut (
      .clock         (clock),
      .reset         (reset),
      .mouse_x       (mouse_x),
      .mouse_y       (mouse_y),
      .mouse_buttons (mouse_buttons),
      .cursor_enable (cursor_enable),
      .in_valid      (in_valid),
      .in_hsync      (in_hsync),
      .in_vsync      (in_vsync),
      .in_x          (in_x),
      .in_y          (in_y),
      .in_color      (in_color),
      .frame_start   (frame_start),
      .bm_we         (bm_we),
      .bm_addr       (bm_addr),
      .bm_data       (bm_data),
      .out_valid     (out_valid),
      .out_hsync     (out_hsync),
      .out_vsync     (out_vsync),
      .out_color     (out_color)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_errors = 0;

   logic [10:0] exp_q [$];
   string       tag_q [$];

   logic [1:0] bm_model [256];
   logic [9:0] m_x, m_y;
   logic [2:0] m_btn;
   logic       m_en;

   task automatic check_eq(input string tag, input logic [10:0] got, input logic [10:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got {v,hs,vs,color}=%h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [10:0] model_out();
      int dx, dy;
      logic [1:0] code;
      logic [7:0] col;
      dx   = int'(in_x) - int'(m_x);
      dy   = int'(in_y) - int'(m_y);
      code = 2'd0;
      if (m_en && in_valid && dx >= 0 && dx < 16 && dy >= 0 && dy < 16)
         code = bm_model[dy*16 + dx];
      case (code)
         2'd0: col = in_color;
         2'd1: col = 8'h00;
         2'd2: col = m_btn[0] ? 8'hFC : (m_btn[1] ? 8'hE0 : 8'hFF);
         default: col = ~in_color;
      endcase
      if (!in_valid) col = 8'h00;
      return {in_valid, in_hsync, in_vsync, col};
   endfunction

   // Inputs are already set; record expectation, advance one cycle, compare the oldest entry.
   task automatic step(input string tag);
      if (reset) begin
         foreach (exp_q[i]) exp_q[i] = '0;
         exp_q.push_back('0);
         m_x = '0; m_y = '0; m_btn = '0; m_en = 1'b0;
      end else begin
         exp_q.push_back(model_out());
         if (frame_start) begin
            m_x = mouse_x; m_y = mouse_y; m_btn = mouse_buttons; m_en = cursor_enable;
         end
      end
      tag_q.push_back(tag);
      if (bm_we) bm_model[bm_addr] = bm_data;
      @(posedge clock);
      @(negedge clock);
      if (exp_q.size() == 2) begin
         string t;
         logic [10:0] e;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         check_eq(t, {out_valid, out_hsync, out_vsync, out_color}, e);
      end
   endtask

   task automatic idle(input int n, input string tag);
      in_valid = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0;
      for (int i = 0; i < n; i++) step(tag);
   endtask

   task automatic pixel(input int x, input int y, input logic [7:0] c, input string tag);
      in_valid = 1'b1;
      in_x     = 10'(x);
      in_y     = 10'(y);
      in_color = c;
      in_hsync = 1'($urandom);
      in_vsync = (y == 0);
      step(tag);
   endtask

   task automatic line(input int y, input int x0, input int x1, input string tag);
      for (int x = x0; x <= x1; x++) pixel(x, y, 8'($urandom), tag);
      in_valid = 1'b0;
   endtask

   task automatic frame(input int mx, input int my, input logic [2:0] btn, input logic en);
      mouse_x = 10'(mx); mouse_y = 10'(my); mouse_buttons = btn; cursor_enable = en;
      frame_start = 1'b1;
      idle(1, "frame_start");
      frame_start = 1'b0;
   endtask

   task automatic bm_write(input int addr, input logic [1:0] d);
      bm_we = 1'b1; bm_addr = 8'(addr); bm_data = d;
      idle(1, "bm_write");
      bm_we = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      mouse_x = '0; mouse_y = '0; mouse_buttons = '0; cursor_enable = 1'b0;
      in_valid = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0;
      in_x = '0; in_y = '0; in_color = '0;
      frame_start = 1'b0; bm_we = 1'b0; bm_addr = '0; bm_data = '0;
      foreach (bm_model[i]) bm_model[i] = 2'd0;
      m_x = '0; m_y = '0; m_btn = '0; m_en = 1'b0;

      idle(2, "reset");
      reset = 1'b0;
      idle(2, "reset_idle");

      // Before any bitmap write the RAM is undefined, so keep the cursor off screen.
      for (int a = 0; a < 256; a++) bm_write(a, 2'd2);

      frame(100, 50, 3'b000, 1'b1);
      line(50, 95, 120, "fill_row50");
      line(65, 98, 118, "fill_row65");
      line(66, 98, 118, "below_cursor");
      line(49, 98, 118, "above_cursor");

      mouse_x = 10'd200;
      line(50, 95, 120, "midframe_old_x");
      line(51, 195, 220, "midframe_no_new_x");
      frame(200, 50, 3'b000, 1'b1);
      line(50, 95, 120, "newframe_old_x");
      line(50, 195, 220, "newframe_new_x");

      frame(630, 490, 3'b000, 1'b1);
      line(490, 620, 639, "edge_row490");
      line(495, 620, 639, "edge_row495");
      line(489, 625, 639, "edge_row489");
      line(0, 0, 20, "nowrap_row0_left");
      line(0, 625, 639, "nowrap_row0_right");

      bm_write(0, 2'd3);
      bm_write(1, 2'd1);
      frame(10, 10, 3'b000, 1'b1);
      pixel(10, 10, 8'h5A, "invert_5A");
      pixel(11, 10, 8'h5A, "outline");
      pixel(12, 10, 8'h5A, "fill_white");
      frame(10, 10, 3'b011, 1'b1);
      pixel(12, 10, 8'h33, "fill_left");
      frame(10, 10, 3'b010, 1'b1);
      pixel(12, 10, 8'h33, "fill_right");
      frame(10, 10, 3'b100, 1'b1);
      pixel(12, 10, 8'h33, "fill_middle");

      // Same-cycle write and read of address 0: old code shown, new one next access.
      bm_we = 1'b1; bm_addr = 8'h00; bm_data = 2'd1;
      pixel(10, 10, 8'h5A, "rdw_old");
      bm_we = 1'b0;
      pixel(10, 10, 8'h5A, "rdw_new");
      in_valid = 1'b0;

      line(10, 8, 14, "pre_reset");
      in_valid = 1'b1; in_x = 10'd12; in_y = 10'd10; in_color = 8'h77;
      reset = 1'b1;
      step("reset_midline");
      reset = 1'b0;
      line(10, 8, 14, "after_reset_hidden");
      frame(10, 10, 3'b000, 1'b0);
      line(10, 8, 14, "enable_off");
      frame(10, 10, 3'b000, 1'b1);
      line(10, 8, 14, "enable_on");

      frame(5, 5, 3'b001, 1'b1);
      for (int r = 0; r < 4; r++) line(5 + r * 5, 0, 24, "random_rows");

      idle(3, "drain");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
